melody_seq: RTL and testbench

//  Tone sequencer feeding the square-wave beeper stage: steps a fixed 16-entry note ROM,

---
 rtl/melody_seq.sv | 207 ++++++++++++++++++++
 tb/tb_melody_seq.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/melody_seq.sv
// Tone sequencer for the square-wave beeper. It steps a fixed 16-entry note ROM and
// drives a half-period compare value and tone enable, with a silent gap after each note.
module melody_seq #(
    parameter int unsigned CLK_FREQ    = 50_000_000,
    parameter int unsigned BEAT_CYCLES = 12_500_000,
    parameter int unsigned GAP_CYCLES  = 1_250_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    input  logic        loop,
    output logic [31:0] half_period,
    output logic        tone_en,
    output logic [3:0]  note_idx,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE,
        NOTE,
        GAP
    } state_e;

    localparam bit          HAS_GAP  = (GAP_CYCLES != 0);
    localparam logic [3:0]  LAST_IDX = 4'd15;

    // Downstream toggles each time its counter passes the compare value, hence /2-1.
    localparam logic [31:0] HP_T1 = 32'(CLK_FREQ / 32'd262 / 32'd2 - 32'd1);
    localparam logic [31:0] HP_T2 = 32'(CLK_FREQ / 32'd294 / 32'd2 - 32'd1);
    localparam logic [31:0] HP_T3 = 32'(CLK_FREQ / 32'd330 / 32'd2 - 32'd1);
    localparam logic [31:0] HP_T4 = 32'(CLK_FREQ / 32'd349 / 32'd2 - 32'd1);
    localparam logic [31:0] HP_T5 = 32'(CLK_FREQ / 32'd392 / 32'd2 - 32'd1);
    localparam logic [31:0] HP_T6 = 32'(CLK_FREQ / 32'd440 / 32'd2 - 32'd1);
    localparam logic [31:0] HP_T7 = 32'(CLK_FREQ / 32'd494 / 32'd2 - 32'd1);

    // ROM entry layout: {tone[3:0], dur[2:0]}; tone 0 is a rest.
    function automatic logic [6:0] rom_entry(input logic [3:0] idx);
        logic [6:0] e;
        case (idx)
            4'd0:    e = {4'd1, 3'd1};
            4'd1:    e = {4'd2, 3'd1};
            4'd2:    e = {4'd3, 3'd1};
            4'd3:    e = {4'd4, 3'd1};
            4'd4:    e = {4'd5, 3'd1};
            4'd5:    e = {4'd6, 3'd1};
            4'd6:    e = {4'd7, 3'd1};
            4'd7:    e = {4'd0, 3'd2};
            4'd8:    e = {4'd7, 3'd1};
            4'd9:    e = {4'd6, 3'd1};
            4'd10:   e = {4'd5, 3'd1};
            4'd11:   e = {4'd4, 3'd1};
            4'd12:   e = {4'd3, 3'd1};
            4'd13:   e = {4'd2, 3'd1};
            4'd14:   e = {4'd1, 3'd1};
            default: e = {4'd0, 3'd4};
        endcase
        return e;
    endfunction

    function automatic logic [31:0] tone_hp(input logic [3:0] tone);
        logic [31:0] hp;
        case (tone)
            4'd1:    hp = HP_T1;
            4'd2:    hp = HP_T2;
            4'd3:    hp = HP_T3;
            4'd4:    hp = HP_T4;
            4'd5:    hp = HP_T5;
            4'd6:    hp = HP_T6;
            4'd7:    hp = HP_T7;
            default: hp = 32'd0;
        endcase
        return hp;
    endfunction

    function automatic logic [31:0] note_cycles(input logic [2:0] dur);
        return 32'(dur) * BEAT_CYCLES - GAP_CYCLES;
    endfunction

    state_e      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [3:0]  note_idx_q, note_idx_d;
    logic [31:0] half_period_q, half_period_d;
    logic        tone_en_q, tone_en_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [6:0]  cur_entry;
    logic [6:0]  next_entry;
    logic [3:0]  next_idx;
    logic [3:0]  next_tone;
    logic        end_entry;
    logic        load_note;
    logic        go_idle;

    assign cur_entry = rom_entry(note_idx_q);

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d       = state_q;
        cnt_d         = (state_q == IDLE) ? 32'd0 : cnt_q + 32'd1;
        note_idx_d    = note_idx_q;
        half_period_d = half_period_q;
        tone_en_d     = tone_en_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        end_entry     = 1'b0;
        load_note     = 1'b0;
        go_idle       = 1'b0;
        next_idx      = note_idx_q + 4'd1;

        case (state_q)
            IDLE: begin
                if (start) begin
                    load_note = 1'b1;
                    next_idx  = 4'd0;
                end
            end
            NOTE: begin
                if (cnt_q == note_cycles(cur_entry[2:0]) - 32'd1) begin
                    if (HAS_GAP) begin
                        state_d   = GAP;
                        cnt_d     = 32'd0;
                        tone_en_d = 1'b0;
                    end else begin
                        end_entry = 1'b1;
                    end
                end
            end
            GAP: begin
                if (cnt_q == GAP_CYCLES - 32'd1) begin
                    end_entry = 1'b1;
                end
            end
            default: go_idle = 1'b1;
        endcase

        // Loop is looked at only here, at the close of the final entry.
        if (end_entry) begin
            if (note_idx_q != LAST_IDX) begin
                load_note = 1'b1;
            end else if (loop) begin
                load_note = 1'b1;
                next_idx  = 4'd0;
            end else begin
                go_idle = 1'b1;
                done_d  = 1'b1;
            end
        end

        next_entry = rom_entry(next_idx);
        next_tone  = next_entry[6:3];

        if (load_note) begin
            state_d       = NOTE;
            cnt_d         = 32'd0;
            note_idx_d    = next_idx;
            tone_en_d     = (next_tone != 4'd0);
            half_period_d = tone_hp(next_tone);
            busy_d        = 1'b1;
        end

        // Stop overrides everything, including a same-cycle start or tune end.
        if (stop) begin
            go_idle = 1'b1;
            done_d  = 1'b0;
        end

        if (go_idle) begin
            state_d       = IDLE;
            cnt_d         = 32'd0;
            note_idx_d    = 4'd0;
            half_period_d = 32'd0;
            tone_en_d     = 1'b0;
            busy_d        = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= 32'd0;
            note_idx_q    <= 4'd0;
            half_period_q <= 32'd0;
            tone_en_q     <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            note_idx_q    <= note_idx_d;
            half_period_q <= half_period_d;
            tone_en_q     <= tone_en_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign half_period = half_period_q;
    assign tone_en     = tone_en_q;
    assign note_idx    = note_idx_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_melody_seq.sv
// Bench for melody_seq: a gapped build and a gapless build run the same directed stimulus
// and are compared every cycle against a timeline model of the tune.
module tb_melody_seq;

    localparam int CLK  = 50_000_000;
    localparam int BEAT = 10;

    logic clk = 1'b0;
    logic rst, start, stop, loop;
    logic chk_en;

    logic [31:0] hp_g, hp_n;
    logic        te_g, te_n;
    logic [3:0]  idx_g, idx_n;
    logic        busy_g, busy_n;
    logic        done_g, done_n;

    int n_cmp = 0;
    int n_err = 0;
    int cyc;

    always #5 clk = ~clk;

    melody_seq #(.CLK_FREQ(CLK), .BEAT_CYCLES(BEAT), .GAP_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .loop(loop),
        .half_period(hp_g), .tone_en(te_g), .note_idx(idx_g), .busy(busy_g), .done(done_g)
    );

    melody_seq #(.CLK_FREQ(CLK), .BEAT_CYCLES(BEAT), .GAP_CYCLES(0)) dut_ng (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .loop(loop),
        .half_period(hp_n), .tone_en(te_n), .note_idx(idx_n), .busy(busy_n), .done(done_n)
    );

    // Tune as a timeline: a playing flag, the entry, and cycles elapsed inside it.
    typedef struct {
        bit play;
        int idx;
        int t;
        bit done;
    } model_t;

    model_t m_g = '{0, 0, 0, 0};
    model_t m_n = '{0, 0, 0, 0};

    function automatic int tone_of(int i);
        if (i < 7)  return i + 1;
        if (i == 7) return 0;
        if (i < 15) return 15 - i;
        return 0;
    endfunction

    function automatic int dur_of(int i);
        if (i == 7)  return 2;
        if (i == 15) return 4;
        return 1;
    endfunction

    function automatic int hp_of(int tone);
        int freq [8] = '{0, 262, 294, 330, 349, 392, 440, 494};
        if (tone == 0) return 0;
        return CLK / freq[tone] / 2 - 1;
    endfunction

    function automatic model_t step(model_t m, logic st, logic sp, logic lp);
        model_t n = m;
        n.done = 0;
        if (sp) begin
            n.play = 0;
            n.idx  = 0;
            n.t    = 0;
        end else if (!m.play) begin
            if (st) begin
                n.play = 1;
                n.idx  = 0;
                n.t    = 0;
            end
        end else if (m.t + 1 == dur_of(m.idx) * BEAT) begin
            n.t = 0;
            if (m.idx < 15) n.idx = m.idx + 1;
            else if (lp) n.idx = 0;
            else begin
                n.play = 0;
                n.idx  = 0;
                n.done = 1;
            end
        end else begin
            n.t = m.t + 1;
        end
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_g <= '{0, 0, 0, 0};
            m_n <= '{0, 0, 0, 0};
        end else begin
            m_g <= step(m_g, start, stop, loop);
            m_n <= step(m_n, start, stop, loop);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cmp_inst(input string pfx, input model_t m, input int gap,
                            input logic [31:0] hp, input logic te, input logic [3:0] idx,
                            input logic bsy, input logic dn);
        int  tone;
        bit  e_te;
        tone = tone_of(m.idx);
        e_te = m.play && (m.t < dur_of(m.idx) * BEAT - gap) && (tone != 0);
        check({pfx, ".tone_en"},     32'(te),  32'(e_te));
        check({pfx, ".half_period"}, hp,       m.play ? 32'(hp_of(tone)) : 32'd0);
        check({pfx, ".note_idx"},    32'(idx), m.play ? 32'(m.idx) : 32'd0);
        check({pfx, ".busy"},        32'(bsy), 32'(m.play));
        check({pfx, ".done"},        32'(dn),  32'(m.done));
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp_inst("gap",   m_g, 2, hp_g, te_g, idx_g, busy_g, done_g);
            cmp_inst("nogap", m_n, 0, hp_n, te_n, idx_n, busy_n, done_n);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_to(input int target);
        while (cyc < target) begin
            tick();
            cyc++;
        end
    endtask

    task automatic start_tune();
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc   = 1;
    endtask

    task automatic stop_tune();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    initial begin
        int on_cnt;
        bit done_seen;
        rst = 1'b0; start = 1'b0; stop = 1'b0; loop = 1'b0; chk_en = 1'b0; cyc = 0;
        #1 rst = 1'b1;
        tick();
        tick();
        check("reset.half_period", hp_g, 32'd0);
        check("reset.tone_en", 32'(te_g), 32'd0);
        check("reset.note_idx", 32'(idx_g), 32'd0);
        check("reset.busy", 32'(busy_g), 32'd0);
        check("reset.done", 32'(done_g), 32'd0);
        chk_en = 1'b1;
        rst = 1'b0;
        tick();

        // First notes and gap timing
        start_tune();
        check("c1.tone_en", 32'(te_g), 32'd1);
        check("c1.half_period", hp_g, 32'd95418);
        check("c1.note_idx", 32'(idx_g), 32'd0);
        run_to(8);
        check("c8.tone_en", 32'(te_g), 32'd1);
        run_to(9);
        check("c9.tone_en", 32'(te_g), 32'd0);
        check("c9.hp_hold", hp_g, 32'd95418);
        check("c9.nogap_tone_en", 32'(te_n), 32'd1);
        run_to(11);
        check("c11.note_idx", 32'(idx_g), 32'd1);
        check("c11.half_period", hp_g, 32'd85033);
        check("c11.nogap_note_idx", 32'(idx_n), 32'd1);
        run_to(51);
        check("entry5.note_idx", 32'(idx_g), 32'd5);
        check("entry5.half_period", hp_g, 32'd56817);
        run_to(71);
        on_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            on_cnt += int'(te_g);
            tick();
            cyc++;
        end
        check("entry7.tone_on_cycles", 32'(on_cnt), 32'd0);
        check("entry8.note_idx", 32'(idx_g), 32'd8);
        check("entry8.half_period", hp_g, 32'd50606);
        run_to(200);
        check("c200.done", 32'(done_g), 32'd0);
        check("c200.busy", 32'(busy_g), 32'd1);
        run_to(201);
        check("c201.done", 32'(done_g), 32'd1);
        check("c201.busy", 32'(busy_g), 32'd0);
        check("c201.half_period", hp_g, 32'd0);
        check("c201.nogap_done", 32'(done_n), 32'd1);
        run_to(202);
        check("c202.done", 32'(done_g), 32'd0);

        // Loop: loop raised mid-tune, sampled only at the end of entry 15
        tick();
        start_tune();
        run_to(150);
        loop = 1'b1;
        run_to(200);
        check("loop.c200.note_idx", 32'(idx_g), 32'd15);
        run_to(201);
        check("loop.c201.note_idx", 32'(idx_g), 32'd0);
        check("loop.c201.busy", 32'(busy_g), 32'd1);
        check("loop.c201.done", 32'(done_g), 32'd0);
        check("loop.c201.half_period", hp_g, 32'd95418);
        loop = 1'b0;
        stop_tune();
        check("loop.stop.busy", 32'(busy_g), 32'd0);

        // Stop during entry 3, then replay
        tick();
        start_tune();
        run_to(33);
        check("stop.pre.note_idx", 32'(idx_g), 32'd3);
        stop_tune();
        check("stop.tone_en", 32'(te_g), 32'd0);
        check("stop.busy", 32'(busy_g), 32'd0);
        check("stop.note_idx", 32'(idx_g), 32'd0);
        check("stop.half_period", hp_g, 32'd0);
        done_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            done_seen |= done_g;
            tick();
        end
        check("stop.no_done", 32'(done_seen), 32'd0);
        start_tune();
        check("replay.note_idx", 32'(idx_g), 32'd0);
        check("replay.half_period", hp_g, 32'd95418);
        check("replay.busy", 32'(busy_g), 32'd1);
        stop_tune();

        // Start and stop together in IDLE; start pulse mid-tune
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        check("startstop.busy", 32'(busy_g), 32'd0);
        tick();
        check("startstop.busy2", 32'(busy_g), 32'd0);
        start_tune();
        run_to(15);
        start = 1'b1;
        tick();
        cyc++;
        start = 1'b0;
        run_to(21);
        check("midstart.c21.note_idx", 32'(idx_g), 32'd2);
        run_to(31);
        check("midstart.c31.note_idx", 32'(idx_g), 32'd3);
        stop_tune();

        // Asynchronous reset mid-gap
        tick();
        start_tune();
        run_to(9);
        check("gap.tone_en", 32'(te_g), 32'd0);
        check("gap.busy", 32'(busy_g), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst.half_period", hp_g, 32'd0);
        check("arst.note_idx", 32'(idx_g), 32'd0);
        check("arst.busy", 32'(busy_g), 32'd0);
        check("arst.nogap_busy", 32'(busy_n), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        check("post_rst.busy", 32'(busy_g), 32'd0);

        // Gapless build: final rest runs contiguously to the end
        start_tune();
        run_to(161);
        check("nogap.c161.note_idx", 32'(idx_n), 32'd15);
        run_to(200);
        check("nogap.c200.note_idx", 32'(idx_n), 32'd15);
        check("nogap.c200.busy", 32'(busy_n), 32'd1);
        run_to(201);
        check("nogap.c201.done", 32'(done_n), 32'd1);
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
